// File: rtl/chess_pkg.sv
// Shared types and constants for the pawn-only chess move controller.
package chess_pkg;

  // One board square: king flag, piece color (1 = black), occupied flag.
  typedef struct packed {
    logic king;
    logic color;
    logic occupied;
  } square_t;

  // Whole board, indexed [row][col]; row 0 is the top, col 0 the left edge.
  typedef square_t [7:0][7:0] board_t;

  typedef enum logic [1:0] {
    RESP_OK        = 2'b00,
    RESP_ILLEGAL   = 2'b01,
    RESP_BAD_SRC   = 2'b10,
    RESP_GAME_OVER = 2'b11
  } resp_code_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_CHECK = 2'b01,
    ST_RESP  = 2'b10
  } state_t;

  localparam logic       WHITE           = 1'b0;
  localparam logic       BLACK           = 1'b1;
  localparam logic [2:0] WHITE_START_ROW = 3'd6;
  localparam logic [2:0] BLACK_START_ROW = 3'd1;

  // Bit positions inside the pawn checker's allow vector.
  localparam int ALLOW_FWD    = 2;
  localparam int ALLOW_DIAG_L = 1;
  localparam int ALLOW_DIAG_R = 0;

  // Opening position: a pawn row and a king for each side.
  function automatic board_t init_board();
    board_t b;
    b = '0;
    for (int c = 0; c < 8; c++) begin
      b[WHITE_START_ROW][c] = '{king: 1'b0, color: WHITE, occupied: 1'b1};
      b[BLACK_START_ROW][c] = '{king: 1'b0, color: BLACK, occupied: 1'b1};
    end
    b[7][4] = '{king: 1'b1, color: WHITE, occupied: 1'b1};
    b[0][4] = '{king: 1'b1, color: BLACK, occupied: 1'b1};
    return b;
  endfunction

endpackage

// File: rtl/pawn.sv
// Pawn move checker: for a pawn of the given color on (i_row, i_col), flags
// which of the three one-row-forward target squares it may move to.
module pawn
  import chess_pkg::*;
(
  input  logic [2:0] i_row,
  input  logic [2:0] i_col,
  input  logic       i_color,
  input  board_t     i_board,
  output logic [2:0] o_allow
);

  logic       w_step_ok;
  logic [2:0] w_step_row;
  logic [2:0] w_col_l;
  logic [2:0] w_col_r;
  square_t    w_fwd_sq;
  square_t    w_left_sq;
  square_t    w_right_sq;

  // White advances toward row 0, black toward row 7; the edge row has no step.
  assign w_step_ok  = (i_color == WHITE) ? (i_row != 3'd0) : (i_row != 3'd7);
  assign w_step_row = (i_color == WHITE) ? (i_row - 3'd1) : (i_row + 3'd1);
  assign w_col_l    = i_col - 3'd1;
  assign w_col_r    = i_col + 3'd1;

  assign w_fwd_sq   = i_board[w_step_row][i_col];
  assign w_left_sq  = i_board[w_step_row][w_col_l];
  assign w_right_sq = i_board[w_step_row][w_col_r];

  // Forward needs an empty square; diagonals need an enemy piece and must not wrap.
  always_comb begin
    // NOTE: a default assignment first means no path leaves a bit unassigned, so no latch.
    o_allow = '0;
    o_allow[ALLOW_FWD]    = w_step_ok && !w_fwd_sq.occupied;
    o_allow[ALLOW_DIAG_L] = w_step_ok && (i_col != 3'd0) &&
                            w_left_sq.occupied && (w_left_sq.color != i_color);
    o_allow[ALLOW_DIAG_R] = w_step_ok && (i_col != 3'd7) &&
                            w_right_sq.occupied && (w_right_sq.color != i_color);
  end

endmodule

// File: rtl/move_controller.sv
// Move controller: accepts a move request, classifies it in one CHECK cycle,
// commits legal moves to the registered board and reports a response code.
// Optional feature: define TWO_STEP_EN to allow a pawn's double step from its
// start row; without it two-row moves are rejected as ILLEGAL.
module move_controller
  import chess_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_src_row,
  input  logic [2:0] req_src_col,
  input  logic [2:0] req_dst_row,
  input  logic [2:0] req_dst_col,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic [1:0] resp_code,
  output logic       turn,
  output logic       game_over,
  output board_t     board_out
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_src_row;
  logic [2:0] r_src_col;
  logic [2:0] r_dst_row;
  logic [2:0] r_dst_col;
  board_t     r_board;
  logic       r_turn;
  logic       r_game_over;
  resp_code_t r_resp_code;

  square_t    w_src_sq;
  square_t    w_dst_sq;
  logic [2:0] w_allow;
  logic [3:0] w_fwd_row;
  logic       w_one_step_ok;
  logic       w_move_ok;
  resp_code_t w_code;
  logic       w_commit;

  assign w_src_sq = r_board[r_src_row][r_src_col];
  assign w_dst_sq = r_board[r_dst_row][r_dst_col];

  pawn u_pawn (
    .i_row   (r_src_row),
    .i_col   (r_src_col),
    .i_color (w_src_sq.color),
    .i_board (r_board),
    .o_allow (w_allow)
  );

  // Row/column arithmetic is done one bit wider so an off-board target never
  // aliases onto a real square.
  assign w_fwd_row = (w_src_sq.color == WHITE) ? ({1'b0, r_src_row} - 4'd1)
                                               : ({1'b0, r_src_row} + 4'd1);

  assign w_one_step_ok = ({1'b0, r_dst_row} == w_fwd_row) &&
    (((r_dst_col == r_src_col) && w_allow[ALLOW_FWD]) ||
     (({1'b0, r_dst_col} == ({1'b0, r_src_col} - 4'd1)) && w_allow[ALLOW_DIAG_L]) ||
     (({1'b0, r_dst_col} == ({1'b0, r_src_col} + 4'd1)) && w_allow[ALLOW_DIAG_R]));

`ifdef TWO_STEP_EN
  logic [2:0] w_start_row;
  logic [2:0] w_mid_row;
  logic [2:0] w_two_row;
  logic       w_two_step_ok;

  // Double step from the start row; both squares passed over must be empty.
  assign w_start_row   = (w_src_sq.color == WHITE) ? WHITE_START_ROW : BLACK_START_ROW;
  assign w_mid_row     = (w_src_sq.color == WHITE) ? (r_src_row - 3'd1) : (r_src_row + 3'd1);
  assign w_two_row     = (w_src_sq.color == WHITE) ? (r_src_row - 3'd2) : (r_src_row + 3'd2);
  assign w_two_step_ok = (r_src_row == w_start_row) && (r_dst_col == r_src_col) &&
                         (r_dst_row == w_two_row) &&
                         !r_board[w_mid_row][r_src_col].occupied && !w_dst_sq.occupied;
  assign w_move_ok     = w_one_step_ok || w_two_step_ok;
`else
  assign w_move_ok = w_one_step_ok;
`endif

  // Classify the latched request in priority order.
  always_comb begin
    w_code = RESP_OK;
    if (r_game_over) begin
      w_code = RESP_GAME_OVER;
    end else if (!w_src_sq.occupied || (w_src_sq.color != r_turn) || w_src_sq.king) begin
      w_code = RESP_BAD_SRC;
    end else if (!w_move_ok) begin
      w_code = RESP_ILLEGAL;
    end
  end

  assign w_commit = (r_state == ST_CHECK) && (w_code == RESP_OK);

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state: CHECK always lasts one cycle; RESP waits for resp_ready.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (req_valid) w_state_nxt = ST_CHECK;
      ST_CHECK: w_state_nxt = ST_RESP;
      ST_RESP:  if (resp_ready) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    req_ready  = (r_state == ST_IDLE);
    resp_valid = (r_state == ST_RESP);
  end

  // Capture the requested coordinates on the accept edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_src_row <= '0;
      r_src_col <= '0;
      r_dst_row <= '0;
      r_dst_col <= '0;
    end else if (req_valid && (r_state == ST_IDLE)) begin
      r_src_row <= req_src_row;
      r_src_col <= req_src_col;
      r_dst_row <= req_dst_row;
      r_dst_col <= req_dst_col;
    end
  end

  // Register the response code at the CHECK->RESP edge; it stays stable through RESP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_resp_code <= RESP_OK;
    end else if (r_state == ST_CHECK) begin
      r_resp_code <= w_code;
    end
  end

  // Game state: commit an OK move on the same edge its code is registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the board is a bank of flops, not a RAM, so it can and must take the opening position on reset.
      r_board     <= init_board();
      r_turn      <= WHITE;
      r_game_over <= 1'b0;
    end else if (w_commit) begin
      r_board[r_dst_row][r_dst_col] <= w_src_sq;
      r_board[r_src_row][r_src_col] <= '0;
      r_turn                        <= ~r_turn;
      if (w_dst_sq.king) begin
        r_game_over <= 1'b1;
      end
    end
  end

  assign resp_code = r_resp_code;
  assign turn      = r_turn;
  assign game_over = r_game_over;
  assign board_out = r_board;

endmodule

// File: tb/tb_move_controller.sv
// Self-checking bench for move_controller: directed scenarios followed by
// randomized moves, all compared every cycle against a move-rules model.
module tb_move_controller;

  logic             clk;
  logic             reset_n;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_src_row, req_src_col, req_dst_row, req_dst_col;
  logic             resp_valid;
  logic             resp_ready;
  logic [1:0]       resp_code;
  logic             turn;
  logic             game_over;
  chess_pkg::board_t board_out;

  move_controller dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_src_row (req_src_row),
    .req_src_col (req_src_col),
    .req_dst_row (req_dst_row),
    .req_dst_col (req_dst_col),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_code   (resp_code),
    .turn        (turn),
    .game_over   (game_over),
    .board_out   (board_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  chess_pkg::board_t m_board;
  logic              m_turn;
  logic              m_over;
  logic              exp_rr, exp_rv;
  logic [1:0]        exp_code;
  logic              chk_en = 1'b0;

  task automatic model_reset();
    m_board = '0;
    for (int c = 0; c < 8; c++) begin
      m_board[6][c] = 3'b001;
      m_board[1][c] = 3'b011;
    end
    m_board[7][4] = 3'b101;
    m_board[0][4] = 3'b111;
    m_turn   = 1'b0;
    m_over   = 1'b0;
    exp_rr   = 1'b1;
    exp_rv   = 1'b0;
    exp_code = 2'b00;
  endtask

  // Move rules in plain signed arithmetic on the model board.
  function automatic logic [1:0] model_code(input int sr, sc, dr, dc);
    chess_pkg::square_t s, t;
    int dir, step, side;
    s = m_board[sr][sc];
    t = m_board[dr][dc];
    if (m_over) return 2'b11;
    if (!s.occupied || s.color != m_turn || s.king) return 2'b10;
    dir  = m_turn ? 1 : -1;
    step = dr - sr;
    side = dc - sc;
    if (step == dir && side == 0 && !t.occupied) return 2'b00;
    if (step == dir && (side == 1 || side == -1) && t.occupied && t.color != m_turn)
      return 2'b00;
`ifdef TWO_STEP_EN
    if (step == 2 * dir && side == 0 && sr == (m_turn ? 1 : 6) &&
        !m_board[sr + dir][sc].occupied && !t.occupied) return 2'b00;
`endif
    return 2'b01;
  endfunction

  task automatic model_commit(input int sr, sc, dr, dc);
    if (m_board[dr][dc].king) m_over = 1'b1;
    m_board[dr][dc] = m_board[sr][sc];
    m_board[sr][sc] = '0;
    m_turn = ~m_turn;
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready",  req_ready,  exp_rr);
      check("resp_valid", resp_valid, exp_rv);
      check("turn",       turn,       m_turn);
      check("game_over",  game_over,  m_over);
      check("board",      board_out,  m_board);
      if (exp_rv)   check("resp_code", resp_code, exp_code);
      if (!reset_n) check("rst_resp_code", resp_code, 2'b00);
    end
  end

  // ---------------- drivers (called at posedge + #1) ----------------
  task automatic do_reset();
    reset_n = 1'b0;
    req_valid = 1'b0;
    resp_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic do_move(input logic [2:0] sr, sc, dr, dc, input int hold,
                         output logic [1:0] code);
    req_valid = 1'b1;
    req_src_row = sr; req_src_col = sc; req_dst_row = dr; req_dst_col = dc;
    @(posedge clk); #1;                 // accept edge -> CHECK
    req_valid = 1'b0;
    req_src_row = 3'($urandom); req_dst_col = 3'($urandom);
    code   = model_code(sr, sc, dr, dc);
    exp_rr = 1'b0;
    exp_rv = 1'b0;
    @(posedge clk); #1;                 // CHECK -> RESP
    if (code == 2'b00) model_commit(sr, sc, dr, dc);
    exp_rv   = 1'b1;
    exp_code = code;
    resp_ready = (hold == 0);
    repeat (hold) begin @(posedge clk); #1; end
    resp_ready = 1'b1;
    @(posedge clk); #1;                 // RESP -> IDLE
    resp_ready = 1'b0;
    exp_rv = 1'b0;
    exp_rr = 1'b1;
  endtask

  task automatic reset_in_check(input logic [2:0] sr, sc, dr, dc);
    req_valid = 1'b1;
    req_src_row = sr; req_src_col = sc; req_dst_row = dr; req_dst_col = dc;
    @(posedge clk); #1;                 // now in CHECK
    req_valid = 1'b0;
    exp_rr = 1'b0;
    #1 reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic ok_move(input logic [2:0] sr, sc, dr, dc);
    logic [1:0] c;
    do_move(sr, sc, dr, dc, 0, c);
    check("seq_ok", c, 2'b00);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] code;
    reset_n = 1'b0;
    req_valid = 1'b0;
    resp_ready = 1'b0;
    req_src_row = '0; req_src_col = '0; req_dst_row = '0; req_dst_col = '0;
    model_reset();
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // Opening position pinned by hand.
    check("init_b64", board_out[6][4], 3'b001);
    check("init_b14", board_out[1][4], 3'b011);
    check("init_b74", board_out[7][4], 3'b101);
    check("init_b04", board_out[0][4], 3'b111);

    // Black moves on white's turn.
    do_move(3'd1, 3'd0, 3'd2, 3'd0, 0, code);
    check("bad_src_code", code, 2'b10);
    check("bad_src_turn", turn, 1'b0);
    check("bad_src_b10", board_out[1][0], 3'b011);

    // First white move, single-cycle response occupancy.
    do_move(3'd6, 3'd4, 3'd5, 3'd4, 0, code);
    check("first_code", code, 2'b00);
    check("first_b54", board_out[5][4], 3'b001);
    check("first_b64", board_out[6][4], 3'b000);
    check("first_turn", turn, 1'b1);

    // March a white pawn to (2,3), then capture the black pawn at (1,2).
    ok_move(1, 7, 2, 7); ok_move(6, 3, 5, 3);
    ok_move(2, 7, 3, 7); ok_move(5, 3, 4, 3);
    ok_move(3, 7, 4, 7); ok_move(4, 3, 3, 3);
    ok_move(4, 7, 5, 7); ok_move(3, 3, 2, 3);
    ok_move(1, 0, 2, 0);
    do_move(3'd2, 3'd3, 3'd1, 3'd2, 0, code);
    check("capture_code", code, 2'b00);
    check("capture_b12", board_out[1][2], 3'b001);
    ok_move(1, 6, 2, 6);
    do_move(3'd6, 3'd0, 3'd5, 3'd7, 0, code);
    check("wrap_code", code, 2'b01);
    check("wrap_turn", turn, 1'b0);

    // Walk another white pawn up and take the black king.
    ok_move(5, 4, 4, 4); ok_move(2, 6, 3, 6);
    ok_move(4, 4, 3, 4); ok_move(3, 6, 4, 6);
    ok_move(3, 4, 2, 4); ok_move(4, 6, 5, 6);
    ok_move(2, 4, 1, 5); ok_move(2, 0, 3, 0);
    do_move(3'd1, 3'd5, 3'd0, 3'd4, 0, code);
    check("king_code", code, 2'b00);
    check("king_over", game_over, 1'b1);
    do_move(3'd3, 3'd0, 3'd4, 3'd0, 2, code);
    check("after_over_code", code, 2'b11);

    // Reset in the middle of an accepted request: no commit survives.
    do_reset();
    reset_in_check(3'd6, 3'd1, 3'd5, 3'd1);
    check("rst_mid_b61", board_out[6][1], 3'b001);
    check("rst_mid_b51", board_out[5][1], 3'b000);
    check("rst_mid_turn", turn, 1'b0);

    // Response held back for five cycles.
    do_move(3'd6, 3'd1, 3'd5, 3'd1, 5, code);
    check("hold_code", code, 2'b00);
    ok_move(1, 1, 2, 1);

    // Double step from the start row.
    do_move(3'd6, 3'd2, 3'd4, 3'd2, 0, code);
`ifdef TWO_STEP_EN
    check("two_step_code", code, 2'b00);
`else
    check("two_step_code", code, 2'b01);
`endif

    // Randomized play.
    for (int n = 0; n < 400; n++) begin
      logic [2:0] sr, sc, dr, dc, dd, dir3;
      int pr[$];
      int pc[$];
      int k;
      int sel;
      if (m_over) begin
        do_move(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
                $urandom_range(2), code);
        do_reset();
        continue;
      end
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          if (m_board[r][c].occupied && !m_board[r][c].king && m_board[r][c].color == m_turn) begin
            pr.push_back(r);
            pc.push_back(c);
          end
      if (pr.size() > 0 && $urandom_range(3) != 0) begin
        k  = $urandom_range(pr.size() - 1);
        sr = 3'(pr[k]);
        sc = 3'(pc[k]);
      end else begin
        sr = 3'($urandom);
        sc = 3'($urandom);
      end
      dir3 = m_turn ? 3'd1 : 3'd7;
      case ($urandom_range(2))
        0:       dd = 3'd7;
        1:       dd = 3'd0;
        default: dd = 3'd1;
      endcase
      sel = $urandom_range(9);
      if (sel <= 6) begin
        dr = sr + dir3;
        dc = sc + dd;
      end else if (sel == 7) begin
        dr = sr + dir3 + dir3;
        dc = sc;
      end else begin
        dr = 3'($urandom);
        dc = 3'($urandom);
      end
      if ($urandom_range(39) == 0) reset_in_check(sr, sc, dr, dc);
      else                         do_move(sr, sc, dr, dc, $urandom_range(3), code);
      repeat ($urandom_range(2)) @(posedge clk);
      #0;
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/move_controller.md
MOVE_CONTROLLER -- requirements
Module: move_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have ports req_valid (input, 1) and req_ready (output, 1): move-request handshake.
REQ-004 SHALL have ports req_src_row, req_src_col, req_dst_row, req_dst_col, each input, 3 bits: requested move. Row 0 is the top of the board; column 0 is the left edge.
REQ-005 SHALL have ports resp_valid (output, 1) and resp_ready (input, 1): response handshake.
REQ-006 SHALL have port resp_code, output, 2 bits: 00 OK, 01 ILLEGAL, 10 BAD_SRC, 11 GAME_OVER.
REQ-007 SHALL have port turn, output, 1 bit: side to move; 0 white, 1 black.
REQ-008 SHALL have port game_over, output, 1 bit: a king has been captured.
REQ-009 SHALL have port board_out, output, [2:0] elements in an [7:0][7:0] array, indexed [row][col]: registered board. Bit0 = occupied, bit1 = color (1 black), bit2 = king.

Function
REQ-010 SHALL use a 3-state FSM: IDLE, CHECK, RESP.
REQ-011 SHALL drive req_ready=1 only in IDLE. On req_valid&&req_ready it latches the four coordinates and moves to CHECK.
REQ-012 SHALL make CHECK last exactly one cycle. At the CHECK->RESP edge it registers resp_code and, if the code is OK, commits the move in the same edge.
REQ-013 SHALL classify moves in this priority: game_over=1 -> GAME_OVER; source empty, or source color != turn, or source is a king -> BAD_SRC; destination not among the allowed moves -> ILLEGAL; otherwise OK.
REQ-014 SHALL allow forward one step: dst_col == src_col, dst_row = src_row-1 for white or src_row+1 for black, and the destination is empty.
REQ-015 SHALL allow diagonal capture: dst_col = src_col±1, same row step as REQ-014, and the destination is occupied by the opposite color.
REQ-016 SHALL reject any destination that falls off the board (wrap-around, e.g. col 7+1) as ILLEGAL; 3-bit coordinates never wrap into a legal square.
REQ-017 SHALL commit a move as follows: destination <= source contents, source <= 000, turn inverts.
REQ-018 SHALL set game_over=1 on a commit whose destination held a king (bit2=1). game_over stays set until reset.
REQ-019 SHALL hold resp_valid=1 with resp_code stable throughout RESP. The FSM returns to IDLE on the edge where resp_ready=1; resp_ready=1 in the first RESP cycle gives 1-cycle occupancy.
REQ-020 SHALL guarantee minimum request-to-request spacing of 3 cycles (IDLE, CHECK, RESP).
REQ-021 SHALL leave board_out, turn and game_over unchanged on any non-OK response.

Reset
REQ-022 SHALL, while reset_n=0 (asynchronously), force: state=IDLE, req_ready=1, resp_valid=0, resp_code=00, turn=0, game_over=0.
REQ-023 SHALL, while reset_n=0, load the board as follows:
- row 6: all 001 (white pawns)
- row 1: all 011 (black pawns)
- [7][4] = 101 (white king)
- [0][4] = 111 (black king)
- all other squares 000
REQ-024 SHALL discard any in-flight request when reset asserts mid-operation; no partial commit occurs.

Configuration
REQ-025 SHALL, with macro TWO_STEP_EN defined, additionally allow a double step:
- the source is on the start row (6 white, 1 black)
- dst_col == src_col and the destination is two rows forward
- both the intermediate and destination squares are empty
REQ-026 SHALL, with TWO_STEP_EN undefined, classify two-row moves as ILLEGAL and contain no logic for them.

Structure
REQ-027 SHALL place in a shared package chess_pkg:
- the square typedef (3-bit struct: king, color, occupied)
- the board typedef (8x8 array of squares)
- the resp_code enum
- the FSM state enum
- constants WHITE=0, BLACK=1, WHITE_START_ROW=6, BLACK_START_ROW=1
REQ-028 SHALL instantiate the existing pawn move-checker module (pawn) once. Its inputs are the latched source row, column and color plus the board register; its 3-bit allow vector (forward, diagLeft, diagRight) feeds REQ-014/015. Two-step logic stays local.

Verification
REQ-029 SHALL cover: reset, then move (6,4)->(5,4) -> resp_code=00, board[5][4]=001, board[6][4]=000, turn=1, resp_valid exactly 2 cycles after the accept edge.
REQ-030 SHALL cover: from reset, a black request (1,0)->(2,0) while turn=0 -> BAD_SRC; board and turn unchanged.
REQ-031 SHALL cover: white pawn at (2,3), black pawn at (1,2), move (2,3)->(1,2) -> OK and board[1][2]=001. Then white (6,0)->(5,7) -> ILLEGAL.
REQ-032 SHALL cover: white pawn diagonal onto the black king at (0,4) -> OK and game_over=1. The next request -> GAME_OVER.
REQ-033 SHALL cover: with TWO_STEP_EN, (6,2)->(4,2) -> OK. The same request without the macro -> ILLEGAL.
REQ-034 SHALL cover: hold resp_ready=0 for 5 cycles in RESP -> resp_valid held and req_ready=0 throughout. Assert reset_n=0 during CHECK -> all reset values, no commit.
